// File: rtl/s32x_pkg.sv
// Shared 32X system-block types: PWM channel modes, timer default
// and the register layouts the system-register decoder packs.
package s32x_pkg;

  typedef enum logic [1:0] {
    PWM_OFF    = 2'b00,
    PWM_OWN    = 2'b01,
    PWM_MIRROR = 2'b10,
    PWM_OFF2   = 2'b11
  } PWM_MODE_t;

  localparam int PWM_TM_DEFAULT = 16;

  typedef struct packed {
    logic [3:0] rsv_hi;
    logic [3:0] tm;
    logic       rtp;
    logic [2:0] rsv_lo;
    logic [1:0] rmd;
    logic [1:0] lmd;
  } PWMCR_t;

  typedef struct packed {
    logic [3:0]  rsv;
    logic [11:0] cyc;
  } CYCR_t;

  typedef struct packed {
    logic        full;
    logic        empty;
    logic [1:0]  rsv;
    logic [11:0] pw;
  } PWR_t;

  // TM=0 selects the default period of 16 cycle ends
  function automatic logic [4:0] tm_limit(input logic [3:0] tm);
    if (tm == 4'd0) return 5'(PWM_TM_DEFAULT);
    return {1'b0, tm};
  endfunction

endpackage

// File: rtl/s32x_pwm_fifo.sv
// Pulse-width FIFO; head lives in mem[0], a push into a full
// FIFO drops the oldest entry so the newest width always lands.
module s32x_pwm_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem   [DEPTH];
  logic [W-1:0]  n_mem [DEPTH];
  logic [LW-1:0] lvl;
  logic [LW-1:0] base;
  logic [LW-1:0] n_lvl;
  logic          sh;

  assign full  = (lvl == LW'(DEPTH));
  assign empty = (lvl == '0);
  assign head  = mem[0];

  always_comb begin
    sh    = (pop && !empty) || (push && full);
    base  = lvl - LW'(sh);
    n_lvl = base;
    n_mem = mem;
    if (sh) begin
      for (int k = 0; k < DEPTH - 1; k++)
        n_mem[k] = mem[k+1];
    end
    if (push) begin
      for (int k = 0; k < DEPTH; k++)
        if (LW'(k) == base) n_mem[k] = wdata;
      n_lvl = base + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      lvl <= n_lvl;
      mem <= n_mem;
    end
  end

endmodule

// File: rtl/s32x_pwm_multi.sv
// Multi-channel PWM sound generator: shared cycle counter, per-channel
// FIFO routing into HOLD registers, and a cycle-end sample timer.
module s32x_pwm_multi
  import s32x_pkg::*;
#(
  parameter int CH    = 2,
  parameter int DEPTH = 3,
  parameter int W     = 12
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CE,
  input  logic [W-1:0]             CYC,
  input  logic [3:0]               TM,
  input  logic                     RTP,
  input  logic [2*CH-1:0]          MD,
  input  logic                     WR_EN,
  input  logic [$clog2(CH+1)-1:0]  WR_CH,
  input  logic [W-1:0]             WR_DATA,
  output logic [CH-1:0]            FULL,
  output logic [CH-1:0]            EMPTY,
  output logic [CH-1:0]            PWM_OUT,
  output logic                     IRQ,
  output logic                     DREQ
);

  localparam int CW = $clog2(CH + 1);
  localparam int SW = $clog2(CH);

  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_last;
  logic          cyc_end;
  logic [4:0]    tcnt;
  logic [4:0]    tcnt_inc;
  logic [W-1:0]  hold [CH];
  logic [W-1:0]  head [CH];
  PWM_MODE_t     mode [CH];
  logic [SW-1:0] src  [CH];
  logic [CH-1:0] used;
  logic [CH-1:0] push;
  logic [CH-1:0] pop;

  always_comb begin
    cnt_last = (CYC == '0) ? '1 : CYC - W'(1);
    cyc_end  = CE && (cnt >= cnt_last);
    tcnt_inc = tcnt + 5'd1;
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign mode[i] = PWM_MODE_t'(MD[2*i +: 2]);
    assign src[i]  = (mode[i] == PWM_MIRROR) ? SW'(CH - 1 - i) : SW'(i);
    assign push[i] = WR_EN && (WR_CH == CW'(i) || WR_CH == CW'(CH));

    s32x_pwm_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (WR_DATA),
      .head  (head[i]),
      .full  (FULL[i]),
      .empty (EMPTY[i])
    );
  end

  // a FIFO pops once per cycle end even if two channels read it
  always_comb begin
    used = '0;
    for (int i = 0; i < CH; i++)
      if (mode[i] == PWM_OWN || mode[i] == PWM_MIRROR)
        used[src[i]] = 1'b1;
    pop = used & {CH{cyc_end}};
  end

  always_comb begin
    PWM_OUT = '0;
    for (int i = 0; i < CH; i++)
      PWM_OUT[i] = (cnt < hold[i]);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (cyc_end) begin
      cnt <= '0;
    end else if (CE) begin
      cnt <= cnt + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < CH; i++) hold[i] <= '0;
    end else if (cyc_end) begin
      for (int i = 0; i < CH; i++) begin
        unique case (mode[i])
          PWM_OWN, PWM_MIRROR:
            if (!EMPTY[src[i]]) hold[i] <= head[src[i]];
          default:
            hold[i] <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tcnt <= '0;
      IRQ  <= 1'b0;
      DREQ <= 1'b0;
    end else begin
      IRQ  <= 1'b0;
      DREQ <= 1'b0;
      if (cyc_end) begin
        if (tcnt_inc >= tm_limit(TM)) begin
          tcnt <= '0;
          IRQ  <= 1'b1;
          DREQ <= RTP;
        end else begin
          tcnt <= tcnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_s32x_pwm_multi.sv
// Directed bench for s32x_pwm_multi (CH=2, DEPTH=3, W=12) with
// hand-computed expectations checked by immediate assertions.
module tb_s32x_pwm_multi;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic [11:0] CYC;
  logic [3:0]  TM;
  logic        RTP;
  logic [3:0]  MD;
  logic        WR_EN;
  logic [1:0]  WR_CH;
  logic [11:0] WR_DATA;
  logic [1:0]  FULL;
  logic [1:0]  EMPTY;
  logic [1:0]  PWM_OUT;
  logic        IRQ;
  logic        DREQ;

  int n_tests = 0;
  int n_fail  = 0;
  int h0, h1, ni, nd, first;

  s32x_pwm_multi #(.CH(2), .DEPTH(3), .W(12)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .CE      (CE),
    .CYC     (CYC),
    .TM      (TM),
    .RTP     (RTP),
    .MD      (MD),
    .WR_EN   (WR_EN),
    .WR_CH   (WR_CH),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .PWM_OUT (PWM_OUT),
    .IRQ     (IRQ),
    .DREQ    (DREQ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    CE    = 1'b0;
    WR_EN = 1'b0;
    ticks(2);
    RST_N = 1'b1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [11:0] d);
    WR_EN   = 1'b1;
    WR_CH   = ch;
    WR_DATA = d;
    tick();
    WR_EN   = 1'b0;
  endtask

  task automatic measure(input int n, output int a, output int b);
    a = 0;
    b = 0;
    for (int k = 0; k < n; k++) begin
      a += int'(PWM_OUT[0]);
      b += int'(PWM_OUT[1]);
      tick();
    end
  endtask

  task automatic count_irq(input int n, input int t0);
    ni = 0;
    nd = 0;
    first = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (IRQ) begin
        ni++;
        if (first == 0) first = t0 + t;
      end
      if (DREQ) nd++;
    end
  endtask

  initial begin
    CYC = 12'd10; TM = 4'd0; RTP = 1'b0; MD = 4'b0101;
    WR_CH = 2'd0; WR_DATA = '0;

    do_reset();
    chk("rst_empty", EMPTY, 2'b11);
    chk("rst_full", FULL, 2'b00);
    chk("rst_pwm", PWM_OUT, 2'b00);
    chk("rst_irq", IRQ, 1'b0);
    chk("rst_dreq", DREQ, 1'b0);

    // basic play: 4/10 and 7/10
    push(2'd0, 12'd4);
    push(2'd1, 12'd7);
    chk("basic_loaded", EMPTY, 2'b00);
    CE = 1'b1;
    ticks(9);
    chk("basic_pre_pwm", PWM_OUT, 2'b00);
    tick();
    chk("basic_popped", EMPTY, 2'b11);
    measure(10, h0, h1);
    chk("basic_hi0", h0, 4);
    chk("basic_hi1", h1, 7);

    // drop-oldest on full
    do_reset();
    CYC = 12'd8;
    push(2'd0, 12'd1);
    push(2'd0, 12'd2);
    push(2'd0, 12'd3);
    chk("full_at3", FULL, 2'b01);
    push(2'd0, 12'd4);
    chk("full_stays", FULL, 2'b01);
    CE = 1'b1;
    ticks(8);
    chk("full_after_pop", FULL, 2'b00);
    measure(8, h0, h1);
    chk("pop_first", h0, 2);
    chk("pop_ch1_idle", h1, 0);
    measure(8, h0, h1);
    chk("pop_second", h0, 3);
    chk("drained", EMPTY, 2'b11);
    measure(8, h0, h1);
    chk("pop_third", h0, 4);
    measure(8, h0, h1);
    chk("hold_kept", h0, 4);

    // mono push, mirror mode, out-of-range channel
    do_reset();
    MD = 4'b0010;
    push(2'd2, 12'd5);
    chk("mono_empty", EMPTY, 2'b00);
    chk("mono_full", FULL, 2'b00);
    push(2'd3, 12'd11);
    push(2'd3, 12'd11);
    chk("wrch3_ignored", FULL, 2'b00);
    push(2'd1, 12'd6);
    CE = 1'b1;
    ticks(8);
    chk("mirror_fifo0_kept", EMPTY, 2'b00);
    measure(8, h0, h1);
    chk("mirror_hi0", h0, 5);
    chk("mirror_off_ch1", h1, 0);
    chk("mirror_fifo1_drained", EMPTY, 2'b10);
    measure(8, h0, h1);
    chk("mirror_hi0_second", h0, 6);

    // timer: TM=3 with DREQ, then without, then TM=0
    do_reset();
    MD = 4'b0000; CYC = 12'd2; TM = 4'd3; RTP = 1'b1;
    CE = 1'b1;
    count_irq(12, 0);
    chk("tm3_irq_count", ni, 2);
    chk("tm3_dreq_count", nd, 2);
    chk("tm3_first", first, 6);
    RTP = 1'b0;
    count_irq(6, 12);
    chk("rtp0_irq_count", ni, 1);
    chk("rtp0_dreq_count", nd, 0);
    chk("rtp0_at", first, 18);
    do_reset();
    TM = 4'd0; RTP = 1'b1;
    CE = 1'b1;
    count_irq(40, 0);
    chk("tm0_irq_count", ni, 1);
    chk("tm0_first", first, 32);

    // CYC shrunk below current count wraps on next CE
    do_reset();
    MD = 4'b0101; CYC = 12'd10; TM = 4'd0; RTP = 1'b0;
    push(2'd0, 12'd3);
    CE = 1'b1;
    ticks(8);
    chk("cyc_chg_pre", PWM_OUT, 2'b00);
    CYC = 12'd5;
    tick();
    chk("cyc_chg_wrap", PWM_OUT, 2'b01);
    measure(5, h0, h1);
    chk("cyc5_hi0", h0, 3);

    // CYC=0 is a 4096-tick period
    do_reset();
    CYC = 12'd0;
    push(2'd0, 12'd100);
    CE = 1'b1;
    ticks(4095);
    chk("cyc0_not_yet", EMPTY, 2'b10);
    tick();
    chk("cyc0_wrap", EMPTY, 2'b11);
    measure(4096, h0, h1);
    chk("cyc0_hi0", h0, 100);

    // push and pop together on an empty FIFO
    do_reset();
    CYC = 12'd4;
    push(2'd0, 12'd6);
    CE = 1'b1;
    ticks(4);
    chk("pp_drained", EMPTY, 2'b11);
    ticks(3);
    push(2'd0, 12'd2);
    chk("pp_count1", EMPTY, 2'b10);
    chk("pp_hold_pwm", PWM_OUT, 2'b01);
    measure(4, h0, h1);
    chk("pp_hold_kept", h0, 4);
    measure(4, h0, h1);
    chk("pp_then_pop", h0, 2);

    // reset in the middle of a cycle
    push(2'd1, 12'd9);
    chk("mid_pre_empty", EMPTY, 2'b01);
    chk("mid_pre_pwm", PWM_OUT, 2'b01);
    RST_N = 1'b0;
    tick();
    chk("mid_rst_pwm", PWM_OUT, 2'b00);
    chk("mid_rst_empty", EMPTY, 2'b11);
    chk("mid_rst_full", FULL, 2'b00);
    chk("mid_rst_irq", {IRQ, DREQ}, 2'b00);
    RST_N = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s32x_pwm_multi.md
# s32x_pwm_multi

Parametrised PWM sound generator for the 32X system block, succeeding the fixed two-channel PWM behind PWMCR/CYCR/PWR. It provides CH output channels, each with a DEPTH-entry pulse-width FIFO and per-channel routing mode. It has a shared cycle counter and a sample timer raising an interrupt and an optional DMA request. It sits behind the system-register decoder, which drives its write and control inputs from the 68k or SH2 side.

## Interface
Parameters:
- CH, 2, number of output channels / FIFOs (2..8)
- DEPTH, 3, FIFO entries per channel (2..16)
- W, 12, pulse-width and cycle-register width

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- CE  in  1  PWM tick enable; all counting advances only when high
- CYC  in  W  cycle length; 0 means 2^W
- TM  in  4  timer period in cycles; 0 means 16
- RTP  in  1  enable DREQ on timer expiry
- MD  in  2*CH  per-channel mode; 00 off, 01 own FIFO, 10 mirror FIFO (CH-1-i), 11 off
- WR_EN  in  1  FIFO write strobe, one push per high CLK
- WR_CH  in  $clog2(CH+1)  target FIFO; value CH = mono, pushes all FIFOs
- WR_DATA  in  W  pulse width to push
- FULL  out  CH  FIFO i holds DEPTH entries
- EMPTY  out  CH  FIFO i holds 0 entries
- PWM_OUT  out  CH  pulse outputs
- IRQ  out  1  one-CLK pulse on timer expiry
- DREQ  out  1  one-CLK pulse on timer expiry when RTP=1

## Operation
- Cycle counter CNT (W bits) increments on CE; on CE with CNT >= CYC-1 (CYC=0 → 2^W-1) CNT <= 0: "cycle end".
- At cycle end, each FIFO whose index is the source of at least one channel with mode 01/10 pops one entry if non-empty. HOLD[i] loads the popped value of its source FIFO. An empty source leaves HOLD[i] unchanged. Mode 00/11 channels load HOLD[i] <= 0.
- PWM_OUT[i] = (CNT < HOLD[i]), decoded from registers only; HOLD >= cycle length gives constant high.
- Write: WR_EN pushes WR_DATA into FIFO WR_CH (all FIFOs if WR_CH==CH). WR_CH > CH ignored.
- Push into full FIFO: oldest entry discarded, new entry appended; FULL stays 1.
- Simultaneous push and pop on the same FIFO: pop takes the current head (if any), push appends. An empty FIFO with both delivers nothing to HOLD and ends with 1 entry.
- Timer counter TCNT (4 bits+1) increments at each cycle end. When incremented value >= TM (TM=0 → 16), TCNT <= 0 and IRQ pulses, plus DREQ if RTP.
- CYC/TM changes take effect immediately; the >= compares guarantee wrap on the next CE if already past.

## Timing
- Reset values: CNT=0, TCNT=0, HOLD=0, FIFOs empty, EMPTY=all 1, FULL=0, PWM_OUT=0, IRQ=0, DREQ=0.
- FULL/EMPTY reflect a write at CLK edge t from t+1.
- A value popped at a cycle end edge drives PWM_OUT from the same edge (CNT=0 onward).
- IRQ/DREQ asserted for exactly the CLK following the cycle-end edge; high for one CLK regardless of CE.
- CE low: no counter, timer or pop activity; writes still accepted.
- RST_N low mid-cycle: all state returns to reset values at that edge; pending FIFO contents lost.

## Structure
- Add to S32X_PKG: PWM_MODE_t enum (OFF, OWN, MIRROR, OFF2), PWM_TM_DEFAULT=16, and reuse PWMCR_t/CYCR_t/PWR_t layouts for decoder packing.
- One sub-module: s32x_pwm_fifo (params DEPTH, W; push, pop, head, full, empty, drop-oldest-on-full), instantiated CH times via generate.
- Counters, routing mux and timer live in s32x_pwm_multi.

## Test plan
- Reset, CYC=10, MD=01/01, push 4 to ch0 and 7 to ch1 → after first cycle end PWM_OUT[0] high 4 of 10 ticks, PWM_OUT[1] high 7 of 10; EMPTY=11.
- DEPTH=3: push 1,2,3,4 to ch0 → FULL[0]=1, successive pops yield 2,3,4, then HOLD holds 4.
- Mono push (WR_CH=CH) value 5 → every FIFO count 1; MD=10 on ch0 with CH=2 plays ch1's FIFO.
- TM=3, RTP=1 → IRQ and DREQ one-CLK pulses every 3rd cycle end; RTP=0 → IRQ only; TM=0 → every 16.
- CNT at 8, CYC changed 10→5 → wrap at next CE; CYC=0 → period 4096 ticks.
- Push and pop same edge on empty FIFO → HOLD unchanged, count 1; RST_N low mid-cycle → all outputs zero next edge.
